// File: rtl/rle_pkg.sv
// Shared constants, word type and control-state encoding for the RLE encoder/decoder pair.
package rle_pkg;

  localparam logic [7:0] ESC        = 8'h07;
  localparam logic [7:0] ZERO_CHAR  = 8'h30;
  localparam logic [7:0] PAD        = 8'h00;
  localparam int         MAX_RUN    = 15;
  localparam int         FIFO_DEPTH = 8;

  typedef logic [3:0][7:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_FLUSH_RUN,
    S_DRAIN,
    S_FINISH
  } state_t;

endpackage

// File: rtl/rle_byte_fifo.sv
// Eight-entry byte FIFO: accepts 0-3 bytes per cycle, releases up to four at once.
// Positions beyond the current fill level read back as PAD, so a partial final
// group comes out already padded.
module rle_byte_fifo
  import rle_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      push_count,
  input  logic [2:0][7:0] push_data,
  input  logic            pop,
  output word_t           pop_data,
  output logic [3:0]      count
);

  logic [7:0] mem [FIFO_DEPTH];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [2:0] pop_n;

  // Number of bytes released by a pop: a full group, or whatever is left.
  always_comb begin
    pop_n = 3'd0;
    if (pop) pop_n = (count >= 4'd4) ? 3'd4 : count[2:0];
  end

  // Present the oldest four bytes, padding positions that hold no data.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pop_data[i] = (4'(i) < count) ? mem[rd_ptr + 3'(i)] : PAD;
    end
  end

  // Pointer and fill-level bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      wr_ptr <= wr_ptr + 3'(push_count);
      rd_ptr <= rd_ptr + pop_n;
      count  <= count + 4'(push_count) - 4'(pop_n);
    end
  end

  // Byte storage write port.
  // NOTE: storage has no reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < push_count) mem[wr_ptr + 3'(i)] <= push_data[i];
    end
  end

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder for "0" characters: scans one byte per cycle, queues coded
// bytes in a small FIFO and hands them downstream as 32-bit words.
module rle_encoder
  import rle_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  input  logic  data_valid,
  input  word_t data_in,
  input  logic  data_last,
  output logic  data_ready,
  output word_t coded_data,
  output logic  result_ready,
  input  logic  read_success,
  output logic  finish
);

  state_t          state, state_next;
  word_t           word_reg;
  logic [1:0]      byte_idx;
  logic            last_reg;
  logic [3:0]      run, run_next;
  logic [7:0]      cur;
  logic [7:0]      lit0, lit1;
  logic [1:0]      lit_n;
  logic            advance;
  logic [1:0]      push_count;
  logic [2:0][7:0] push_data;
  logic            pop;
  word_t           pop_data;
  logic [3:0]      fifo_count;
  logic            space_ok;
  logic            gap;

  assign cur      = word_reg[byte_idx];
  assign space_ok = fifo_count <= 4'(FIFO_DEPTH - 3);

  // A literal ESC is escaped as ESC,PAD; every other non-zero byte is itself.
  assign lit0  = cur;
  assign lit1  = PAD;
  assign lit_n = (cur == ESC) ? 2'd2 : 2'd1;

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state, handshake outputs and the bytes emitted for the current scan step.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    data_ready = 1'b0;
    finish     = 1'b0;
    push_count = 2'd0;
    push_data  = '0;
    run_next   = run;
    advance    = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: begin
        data_ready = 1'b1;
        if (data_valid) state_next = S_SCAN;
      end
      S_SCAN: if (space_ok) begin
        advance = 1'b1;
        if (cur == ZERO_CHAR) begin
          if (run == 4'(MAX_RUN - 1)) begin
            push_data[0] = ESC;
            push_data[1] = 8'(MAX_RUN);
            push_count   = 2'd2;
            run_next     = 4'd0;
          end else begin
            run_next = run + 4'd1;
          end
        end else if (run >= 4'd2 && cur == ESC) begin
          // Run code plus escaped ESC would be four bytes: emit the run now and
          // revisit the ESC byte next cycle with the run cleared.
          push_data[0] = ESC;
          push_data[1] = {4'h0, run};
          push_count   = 2'd2;
          run_next     = 4'd0;
          advance      = 1'b0;
        end else begin
          if (run == 4'd0) begin
            push_data[0] = lit0;
            push_data[1] = lit1;
            push_count   = lit_n;
          end else if (run == 4'd1) begin
            push_data[0] = ZERO_CHAR;
            push_data[1] = lit0;
            push_data[2] = lit1;
            push_count   = lit_n + 2'd1;
          end else begin
            push_data[0] = ESC;
            push_data[1] = {4'h0, run};
            push_data[2] = cur;
            push_count   = 2'd3;
          end
          run_next = 4'd0;
        end
        if (advance && byte_idx == 2'd3) state_next = last_reg ? S_FLUSH_RUN : S_LOAD;
      end
      S_FLUSH_RUN: if (space_ok) begin
        if (run == 4'd1) begin
          push_data[0] = ZERO_CHAR;
          push_count   = 2'd1;
        end else if (run >= 4'd2) begin
          push_data[0] = ESC;
          push_data[1] = {4'h0, run};
          push_count   = 2'd2;
        end
        run_next   = 4'd0;
        state_next = S_DRAIN;
      end
      S_DRAIN: if (fifo_count == 4'd0 && (!result_ready || read_success)) state_next = S_FINISH;
      S_FINISH: begin
        finish     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Input word capture, byte pointer and pending zero-run length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_reg <= '0;
      byte_idx <= 2'd0;
      last_reg <= 1'b0;
      run      <= 4'd0;
    end else begin
      run <= run_next;
      if (state == S_LOAD && data_valid) begin
        word_reg <= data_in;
        byte_idx <= 2'd0;
        last_reg <= data_last;
      end else if (advance) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  // Pop a full group any time the output is free; partial groups only while draining.
  assign pop = !result_ready && !gap &&
               (fifo_count >= 4'd4 || (state == S_DRAIN && fifo_count != 4'd0));

  rle_byte_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_count (push_count),
    .push_data  (push_data),
    .pop        (pop),
    .pop_data   (pop_data),
    .count      (fifo_count)
  );

  // Output word register: hold until acknowledged, then one idle cycle before the next word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coded_data   <= '0;
      result_ready <= 1'b0;
      gap          <= 1'b0;
    end else begin
      gap <= 1'b0;
      if (result_ready && read_success) begin
        result_ready <= 1'b0;
        gap          <= 1'b1;
      end else if (pop) begin
        coded_data   <= pop_data;
        result_ready <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rle_encoder.md
RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 start  input  1  begin a message; sampled only in IDLE.
REQ-004 data_valid  input  1  data_in/data_last valid.
REQ-005 data_in  input  [3:0][7:0]  raw word; byte 0 is the first character.
REQ-006 data_last  input  1  marks the final word of the message.
REQ-007 data_ready  output  1  encoder accepts a word this cycle.
REQ-008 coded_data  output  [3:0][7:0]  encoded word for the decoder; byte 0 first.
REQ-009 result_ready  output  1  coded_data valid, held until read_success.
REQ-010 read_success  input  1  downstream consumed coded_data.
REQ-011 finish  output  1  one-cycle pulse: message completely delivered.

Function
REQ-012 Encoding: a run of k consecutive 8'h30 ("0") characters with k>=2 SHALL emit ESC (8'h07), then count byte k (binary, 2..15).
REQ-013 Runs longer than 15 SHALL be split: emit ESC,8'h0F per 15 characters; a remainder of 1 SHALL be emitted as literal "0", and a remainder of 2..14 as ESC,count.
REQ-014 A single isolated "0" SHALL be emitted as literal 8'h30.
REQ-015 A literal 8'h07 input byte SHALL emit ESC,8'h00.
REQ-016 All other bytes SHALL pass through unchanged, in order.
REQ-017 Runs SHALL continue across word boundaries; a run terminates on a non-"0" byte or at the end of the last word.
REQ-018 The encoder SHALL scan one input byte per cycle, byte 0 to 3, and push 0-3 output bytes per cycle into the byte FIFO.
REQ-019 States: IDLE -> (start) LOAD -> (data_valid&&data_ready) SCAN -> after byte 3: LOAD if not last, else FLUSH_RUN -> DRAIN -> FINISH -> IDLE.
REQ-020 data_ready SHALL be 1 only in LOAD; a word is accepted on data_valid&&data_ready.
REQ-021 SCAN SHALL stall, without consuming a byte, while FIFO free space < 3.
REQ-022 FLUSH_RUN SHALL emit any pending run per REQ-012..014 in one cycle.
REQ-023 When the FIFO holds >=4 bytes, the encoder SHALL pop 4 bytes into coded_data and raise result_ready the next cycle.
REQ-024 In DRAIN, a remaining partial group of 1-3 bytes SHALL be padded with 8'h00 in the high byte positions and emitted as a final word.
REQ-025 result_ready SHALL stay 1 and coded_data SHALL stay stable until read_success=1 is sampled.
REQ-026 After read_success, result_ready SHALL go 0 for at least one cycle before the next word, which tolerates a registered acknowledge.
REQ-027 read_success while result_ready=0 SHALL be ignored.
REQ-028 finish SHALL pulse for exactly one cycle, one cycle after the last word is acknowledged; an empty message (last word with zero output bytes is impossible) needs no special case.
REQ-029 start outside IDLE SHALL be ignored.

Reset
REQ-030 When rst_n=0 at a clock edge: state=IDLE, FIFO emptied, run count=0, data_ready=0, result_ready=0, finish=0, coded_data=32'h0.
REQ-031 Reset mid-message SHALL discard all partial data; the next start begins a fresh message.

Structure
REQ-032 Package rle_pkg SHALL hold ESC=8'h07, ZERO_CHAR=8'h30, PAD=8'h00, MAX_RUN=15, and the state enum, shared with the decoder.
REQ-033 Sub-module rle_byte_fifo: depth 8, pushes 0-3 bytes per cycle, pops 4 bytes, exposes count; bytes popped together with padding on the flush request.

Verification
REQ-034 Input {"A","B","C","D"} last -> one word "A","B","C","D", then finish pulse.
REQ-035 Input "A","0","0","0" / "0","B","C","D" last -> words "A",07,04,"B" and "C","D",00,00.
REQ-036 Input "A",07,"B","C" last -> words "A",07,00,"B" and "C",00,00,00.
REQ-037 Input of 17 "0"s then "X","Y","Z" (5 words) -> words 07,0F,07,02 and "X","Y","Z",00.
REQ-038 read_success held off for 5 cycles -> coded_data unchanged and result_ready=1 throughout; a single acknowledge advances exactly one word.
REQ-039 rst_n=0 during SCAN of word 2 -> all outputs return to reset values the next cycle; a new message "ABCD" encodes correctly.
